// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, flag indices, field access and
// canonical special-value construction for any EXP_W/MAN_W up to 64 bits total.
package fp_pkg;

  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_e;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INEXACT   = 0;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_INVALID   = 3;

  function automatic logic field_sign(word_t x, int unsigned exp_w, int unsigned man_w);
    return x[exp_w+man_w];
  endfunction

  function automatic word_t field_exp(word_t x, int unsigned exp_w, int unsigned man_w);
    return (x >> man_w) & ((word_t'(1) << exp_w) - word_t'(1));
  endfunction

  function automatic word_t field_frac(word_t x, int unsigned man_w);
    return x & ((word_t'(1) << man_w) - word_t'(1));
  endfunction

  // Subnormals (exp=0, frac!=0) deliberately classify as ZERO: they are flushed.
  function automatic cls_e classify(word_t e, word_t f, int unsigned exp_w);
    word_t ones;
    ones = (word_t'(1) << exp_w) - word_t'(1);
    if (e == '0)        return ZERO;
    else if (e == ones) return (f == '0) ? INF : NAN;
    else                return NORM;
  endfunction

  function automatic word_t make_zero(logic sign, int unsigned exp_w, int unsigned man_w);
    return word_t'(sign) << (exp_w + man_w);
  endfunction

  function automatic word_t make_inf(logic sign, int unsigned exp_w, int unsigned man_w);
    return make_zero(sign, exp_w, man_w) |
           (((word_t'(1) << exp_w) - word_t'(1)) << man_w);
  endfunction

  function automatic word_t make_qnan(int unsigned exp_w, int unsigned man_w);
    return make_inf(1'b0, exp_w, man_w) | (word_t'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result stream interface for fp_mult_pipe; the multiplier is the slave.
interface fp_mult_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [3:0]   out_flags;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational normalise/round/pack of a raw mantissa product.
// FP_MULT_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic [EXP_W+1:0]         esum_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  output logic [EXP_W+MAN_W:0]     res_c_o,
  output logic [FLAG_W-1:0]        flags_c_o
);
  localparam int unsigned W       = 1 + EXP_W + MAN_W;
  localparam int unsigned ES_W    = EXP_W + 2;
  localparam int unsigned P_W     = 2 * MAN_W + 2;
  localparam int unsigned FR_W    = MAN_W + 1;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  logic [P_W-2:0]  norm;
  logic [MAN_W-1:0] frac;
  logic            guard;
  logic            sticky;
  logic            inc;
  logic [FR_W-1:0] frac_r;
  logic [ES_W-1:0] exp_r;

  always_comb begin
    // Drop the hidden bit; a product in [1,2) needs one extra left shift.
    norm   = prod_i[P_W-1] ? prod_i[P_W-2:0] : {prod_i[P_W-3:0], 1'b0};
    frac   = norm[2*MAN_W:MAN_W+1];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
`ifdef FP_MULT_RNE_EN
    inc    = guard & (sticky | frac[0]);
`else
    inc    = 1'b0;
`endif
    // A carry out leaves the fraction at zero, i.e. mantissa 1.0 one binade up.
    frac_r = {1'b0, frac} + FR_W'(inc);
    exp_r  = esum_i + ES_W'(prod_i[P_W-1]) + ES_W'(frac_r[MAN_W]);

    res_c_o   = {sign_i, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_c_o = '0;
    flags_c_o[FLAG_INEXACT] = guard | sticky;

    if ($signed(exp_r) >= $signed(ES_W'(EXP_MAX))) begin
      res_c_o = W'(make_inf(sign_i, EXP_W, MAN_W));
      flags_c_o[FLAG_OVERFLOW] = 1'b1;
      flags_c_o[FLAG_INEXACT]  = 1'b1;
    end else if ($signed(exp_r) <= $signed(ES_W'(0))) begin
      res_c_o = W'(make_zero(sign_i, EXP_W, MAN_W));
      flags_c_o[FLAG_UNDERFLOW] = 1'b1;
      flags_c_o[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier with valid/ready backpressure.
// Rounding mode: FP_MULT_RNE_EN defined -> nearest-even, else truncate.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_mult_pipe_if.slave bus
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned ES_W = EXP_W + 2;
  localparam int unsigned M_W  = MAN_W + 1;
  localparam int unsigned P_W  = 2 * M_W;

  logic adv;

  word_t            a_w, b_w;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  cls_e             a_cls, b_cls;
  logic             nan_any, inf_zero, snan;

  logic              s1_valid_q, s2_valid_q, out_valid_q;
  logic              s1_sign_d, s1_sign_q, s2_sign_q;
  logic [ES_W-1:0]   s1_esum_d, s1_esum_q, s2_esum_q;
  logic [M_W-1:0]    s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
  logic [P_W-1:0]    s2_prod_q;
  logic              s1_spec_d, s1_spec_q, s2_spec_q;
  logic [W-1:0]      s1_spec_res_d, s1_spec_res_q, s2_spec_res_q;
  logic [FLAG_W-1:0] s1_spec_flags_d, s1_spec_flags_q, s2_spec_flags_q;

  logic [W-1:0]      rp_res, out_res_d, out_res_q;
  logic [FLAG_W-1:0] rp_flags, out_flags_d, out_flags_q;

  // Whole pipe moves together; bubbles are held as well when stalled.
  always_comb adv = !out_valid_q | bus.out_ready;

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_flags = out_flags_q;

  // S1: unpack, classify, exponent sum and special-value resolution.
  always_comb begin
    a_w    = word_t'(bus.in_a);
    b_w    = word_t'(bus.in_b);
    a_exp  = EXP_W'(field_exp(a_w, EXP_W, MAN_W));
    b_exp  = EXP_W'(field_exp(b_w, EXP_W, MAN_W));
    a_frac = MAN_W'(field_frac(a_w, MAN_W));
    b_frac = MAN_W'(field_frac(b_w, MAN_W));
    a_cls  = classify(word_t'(a_exp), word_t'(a_frac), EXP_W);
    b_cls  = classify(word_t'(b_exp), word_t'(b_frac), EXP_W);

    s1_sign_d = field_sign(a_w, EXP_W, MAN_W) ^ field_sign(b_w, EXP_W, MAN_W);
    s1_esum_d = ES_W'(a_exp) + ES_W'(b_exp) - ES_W'(BIAS);
    s1_ma_d   = {1'b1, a_frac};
    s1_mb_d   = {1'b1, b_frac};

    nan_any  = (a_cls == NAN) || (b_cls == NAN);
    inf_zero = ((a_cls == INF) && (b_cls == ZERO)) || ((a_cls == ZERO) && (b_cls == INF));
    snan     = ((a_cls == NAN) && !a_frac[MAN_W-1]) || ((b_cls == NAN) && !b_frac[MAN_W-1]);

    s1_spec_d       = 1'b0;
    s1_spec_res_d   = '0;
    s1_spec_flags_d = '0;
    if (nan_any || inf_zero) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = W'(make_qnan(EXP_W, MAN_W));
      s1_spec_flags_d[FLAG_INVALID] = inf_zero | snan;
    end else if ((a_cls == INF) || (b_cls == INF)) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = W'(make_inf(s1_sign_d, EXP_W, MAN_W));
    end else if ((a_cls == ZERO) || (b_cls == ZERO)) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = W'(make_zero(s1_sign_d, EXP_W, MAN_W));
    end
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign_i    (s2_sign_q),
    .esum_i    (s2_esum_q),
    .prod_i    (s2_prod_q),
    .res_c_o   (rp_res),
    .flags_c_o (rp_flags)
  );

  always_comb begin
    out_res_d   = s2_spec_q ? s2_spec_res_q   : rp_res;
    out_flags_d = s2_spec_q ? s2_spec_flags_q : rp_flags;
  end

  // Control and output registers; reset drops every in-flight product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
    end
  end

  // Datapath registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q       <= s1_sign_d;
      s1_esum_q       <= s1_esum_d;
      s1_ma_q         <= s1_ma_d;
      s1_mb_q         <= s1_mb_d;
      s1_spec_q       <= s1_spec_d;
      s1_spec_res_q   <= s1_spec_res_d;
      s1_spec_flags_q <= s1_spec_flags_d;
      s2_sign_q       <= s1_sign_q;
      s2_esum_q       <= s1_esum_q;
      s2_prod_q       <= P_W'(s1_ma_q) * P_W'(s1_mb_q);
      s2_spec_q       <= s1_spec_q;
      s2_spec_res_q   <= s1_spec_res_q;
      s2_spec_flags_q <= s1_spec_flags_q;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (single precision): directed vectors,
// latency, backpressure stream and mid-flight reset.
module tb_fp_mult_pipe;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INX  = 4'b0001;
  localparam logic [3:0] F_UNF  = 4'b0010;
  localparam logic [3:0] F_OVF  = 4'b0100;
  localparam logic [3:0] F_INV  = 4'b1000;
`ifdef FP_MULT_RNE_EN
  localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   next_id = 0;
  logic ready_hold = 1'b1;
  logic bp_en = 1'b0;

  // Sole driver of out_ready: either held level or the 1,0,0,1 pattern.
  always begin : ready_drv
    int idx;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) begin
        bus.out_ready = pat[idx];
        idx = (idx + 1) % 4;
      end else begin
        bus.out_ready = ready_hold;
        idx = 0;
      end
    end
  end

  // Monitor: a result transfers at the next edge whenever valid & ready.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && !bus.out_ready) begin
      vectors++;
      if (bus.in_ready) begin
        errors++;
        $display("FAIL stall_in_ready: in_ready=%b while stalled, required 0", bus.in_ready);
      end
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: res=%h flags=%b with no pending product", bus.out_res, bus.out_flags);
      end else begin
        e = sb.pop_front();
        if (bus.out_res !== e.res || bus.out_flags !== e.flags) begin
          errors++;
          $display("FAIL vec%0d: got res=%h flags=%b, required res=%h flags=%b",
                   e.id, bus.out_res, bus.out_flags, e.res, e.flags);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [3:0] flags);
    int n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end else begin
      e.res = res; e.flags = flags; e.id = next_id;
      sb.push_back(e);
    end
    next_id++;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d products outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_res",   bus.out_res,        32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #2;

    // 2 x 3 with exact-latency check.
    send(32'h40000000, 32'h40400000, 32'h40C00000, F_NONE);
    @(negedge clk); chk("lat_c1", 32'(bus.out_valid), 32'd0);
    @(negedge clk); chk("lat_c2", 32'(bus.out_valid), 32'd0);
    @(negedge clk); chk("lat_c3", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #2;

    send(32'h3F800001, 32'h3FC00000, TIE_RES,      F_INX);
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, F_INX);
    send(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, F_OVF | F_INX);
    send(32'h00800000, 32'h00800000, 32'h00000000, F_UNF | F_INX);
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, F_INV);
    send(32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE);
    send(32'h7F800001, 32'h3F800000, 32'h7FC00000, F_INV);
    send(32'h7FC00000, 32'h3F800000, 32'h7FC00000, F_NONE);
    send(32'h00000001, 32'h3F800000, 32'h00000000, F_NONE);
    drain();

    // Back-to-back stream under the 1,0,0,1 out_ready pattern.
    bp_en = 1'b1;
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE);
    send(32'h40000000, 32'h40000000, 32'h40800000, F_NONE);
    send(32'hC0000000, 32'h40400000, 32'hC0C00000, F_NONE);
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, F_NONE);
    send(32'h40400000, 32'h40400000, 32'h41100000, F_NONE);
    send(32'hBF800000, 32'hBF800000, 32'h3F800000, F_NONE);
    send(32'h00000000, 32'hC0000000, 32'h80000000, F_NONE);
    send(32'h40000000, 32'h40400000, 32'h40C00000, F_NONE);
    drain();
    bp_en = 1'b0;
    ready_hold = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Fill the pipe while stalled, then reset with three products in flight.
    send(32'h3F800000, 32'h40000000, 32'h40000000, F_NONE);
    send(32'h40000000, 32'h40000000, 32'h40800000, F_NONE);
    send(32'h40400000, 32'h40000000, 32'h40C00000, F_NONE);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_hold = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (5) @(posedge clk);
    #2;
    send(32'h3F800000, 32'h40400000, 32'h40400000, F_NONE);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
